// File: rtl/hs_tx_sequencer_pkg.sv
// Shared types and constants for the D-PHY HS transmit sequencer.
package hs_tx_pkg;

    typedef enum logic [2:0] {
        IDLE, LPX, PREPARE, ZERO, SYNC, DATA, TRAIL, EXIT
    } hs_state_e;

    // LP line levels packed as {lp_dp, lp_dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

endpackage

// File: rtl/hs_tx_sequencer_if.sv
// PPI byte request side plus serializer/LP driver side of one HS lane.
interface hs_tx_sequencer_if;
    logic       TxRequestHS;
    logic [7:0] TxDataHS;
    logic       TxReadyHS;
    logic       Stopstate;
    logic       ser_en;
    logic [7:0] tx_byte_data;
    logic       hs_drv_en;
    logic       lp_dp;
    logic       lp_dn;

    modport master (
        output TxRequestHS, TxDataHS,
        input  TxReadyHS, Stopstate, ser_en, tx_byte_data, hs_drv_en, lp_dp, lp_dn
    );

    modport slave (
        input  TxRequestHS, TxDataHS,
        output TxReadyHS, Stopstate, ser_en, tx_byte_data, hs_drv_en, lp_dp, lp_dn
    );
endinterface

// File: rtl/hs_tx_sequencer_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module hs_tx_timer #(
    parameter int TW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [TW-1:0] val_i,
    output logic          done_o
);
    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/hs_tx_sequencer.sv
// Per-lane HS burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11.
module hs_tx_sequencer
    import hs_tx_pkg::*;
#(
    parameter int         T_LPX        = 4,
    parameter int         T_HS_PREPARE = 3,
    parameter int         T_HS_ZERO    = 6,
    parameter int         T_HS_TRAIL   = 4,
    parameter int         T_HS_EXIT    = 5,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TW           = 8
) (
    input  logic             Byte_clk,
    input  logic             Tx_rst_n,
    hs_tx_sequencer_if.slave bus
);
    hs_state_e     state_q, state_d;
    logic          tmr_load, tmr_done;
    logic [TW-1:0] tmr_val;
    logic          accept;

    logic [1:0] lp_q, lp_d;
    logic       stop_q, stop_d, ser_q, ser_d, hs_q, hs_d, rdy_q, rdy_d;
    logic [7:0] byte_q, byte_d;
    logic       last_bit_q, last_bit_d;

    assign accept = (state_q == DATA) && bus.TxRequestHS;

    hs_tx_timer #(.TW(TW)) u_timer (
        .clk_i  (Byte_clk),
        .rst_ni (Tx_rst_n),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.TxRequestHS) state_d = LPX;
            LPX:     if (tmr_done) state_d = PREPARE;
            PREPARE: if (tmr_done) state_d = ZERO;
            ZERO:    if (tmr_done) state_d = SYNC;
            SYNC:    state_d = bus.TxRequestHS ? DATA : TRAIL;
            DATA:    if (!bus.TxRequestHS) state_d = TRAIL;
            TRAIL:   if (tmr_done) state_d = EXIT;
            EXIT:    if (tmr_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The timer is loaded on the edge that enters a timed state
        tmr_load = (state_d != state_q);
        unique case (state_d)
            LPX:     tmr_val = TW'(T_LPX - 1);
            PREPARE: tmr_val = TW'(T_HS_PREPARE - 1);
            ZERO:    tmr_val = TW'(T_HS_ZERO - 1);
            TRAIL:   tmr_val = TW'(T_HS_TRAIL - 1);
            EXIT:    tmr_val = TW'(T_HS_EXIT - 1);
            default: tmr_val = '0;
        endcase
    end

    // Outputs are decoded from the next state so they flip on the entering edge
    always_comb begin
        lp_d   = (state_d == LPX) ? LP01 : (state_d inside {IDLE, EXIT}) ? LP11 : LP00;
        hs_d   = state_d inside {PREPARE, ZERO, SYNC, DATA, TRAIL};
        ser_d  = state_d inside {ZERO, SYNC, DATA, TRAIL};
        stop_d = (state_d == IDLE);
        rdy_d  = (state_d == DATA);

        last_bit_d = last_bit_q;
        if (state_d == SYNC && state_q != SYNC)
            last_bit_d = SYNC_BYTE[7];
        else if (accept)
            last_bit_d = bus.TxDataHS[7];

        byte_d = 8'h00;
        if (accept)
            byte_d = bus.TxDataHS;
        else if (state_d == SYNC)
            byte_d = SYNC_BYTE;
        else if (state_d == TRAIL)
            byte_d = {8{~last_bit_q}};
    end

    always_ff @(posedge Byte_clk or negedge Tx_rst_n) begin
        if (!Tx_rst_n) begin
            state_q    <= IDLE;
            lp_q       <= LP11;
            stop_q     <= 1'b1;
            ser_q      <= 1'b0;
            hs_q       <= 1'b0;
            rdy_q      <= 1'b0;
            byte_q     <= 8'h00;
            last_bit_q <= SYNC_BYTE[7];
        end else begin
            state_q    <= state_d;
            lp_q       <= lp_d;
            stop_q     <= stop_d;
            ser_q      <= ser_d;
            hs_q       <= hs_d;
            rdy_q      <= rdy_d;
            byte_q     <= byte_d;
            last_bit_q <= last_bit_d;
        end
    end

    assign bus.lp_dp        = lp_q[1];
    assign bus.lp_dn        = lp_q[0];
    assign bus.Stopstate    = stop_q;
    assign bus.ser_en       = ser_q;
    assign bus.hs_drv_en    = hs_q;
    assign bus.TxReadyHS    = rdy_q;
    assign bus.tx_byte_data = byte_q;
endmodule

// File: tb/tb_hs_tx_sequencer.sv
// Drives randomized HS bursts and compares every cycle against a burst-level trace model.
module tb_hs_tx_sequencer;

    localparam int N_LPX = 4, N_PREP = 3, N_ZERO = 6, N_TRAIL = 4, N_EXIT = 5;
    localparam logic [7:0] SYNC_B = 8'hB8;

    typedef struct packed {
        logic [1:0] lp;
        logic       stop;
        logic       ser;
        logic       hs;
        logic       rdy;
        logic [7:0] b;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    obs_t expq[$];

    always #5 clk = ~clk;

    hs_tx_sequencer_if bus();

    hs_tx_sequencer dut (
        .Byte_clk (clk),
        .Tx_rst_n (rst_n),
        .bus      (bus)
    );

    function automatic obs_t sample();
        obs_t o;
        o = {bus.lp_dp, bus.lp_dn, bus.Stopstate, bus.ser_en, bus.hs_drv_en,
             bus.TxReadyHS, bus.tx_byte_data};
        return o;
    endfunction

    function automatic obs_t mk(logic [1:0] lp, logic st, logic se, logic hs, logic rd, logic [7:0] b);
        obs_t o;
        o = '{lp, st, se, hs, rd, b};
        return o;
    endfunction

    // Expected per-cycle trace of a whole burst, starting the cycle after the request is seen
    function automatic void build(input int n, input logic [7:0] pl[], input logic req_after);
        logic last;
        expq.delete();
        last = SYNC_B[7];
        repeat (N_LPX)  expq.push_back(mk(2'b01, 0, 0, 0, 0, 8'h00));
        repeat (N_PREP) expq.push_back(mk(2'b00, 0, 0, 1, 0, 8'h00));
        repeat (N_ZERO) expq.push_back(mk(2'b00, 0, 1, 1, 0, 8'h00));
        expq.push_back(mk(2'b00, 0, 1, 1, 0, SYNC_B));
        if (n > 0) begin
            expq.push_back(mk(2'b00, 0, 1, 1, 1, 8'h00));
            for (int i = 0; i < n; i++) expq.push_back(mk(2'b00, 0, 1, 1, 1, pl[i]));
            last = pl[n-1][7];
        end
        repeat (N_TRAIL) expq.push_back(mk(2'b00, 0, 1, 1, 0, {8{~last}}));
        repeat (N_EXIT)  expq.push_back(mk(2'b11, 0, 0, 0, 0, 8'h00));
        expq.push_back(mk(2'b11, 1, 0, 0, 0, 8'h00));
        expq.push_back(req_after ? mk(2'b01, 0, 0, 0, 0, 8'h00) : mk(2'b11, 1, 0, 0, 0, 8'h00));
    endfunction

    // pulse>0: request held for that many edges regardless of handshake.
    // abort_at>=0: assert reset right after that cycle's comparison.
    task automatic run_burst(input string name, input int n, input logic [7:0] pl[],
                             input int pulse, input logic req_after, input int abort_at);
        int   k, drop;
        bit   idle_ok;
        obs_t o;
        idle_ok = 1'b0;
        for (int w = 0; w < 40 && !idle_ok; w++) begin
            @(negedge clk);
            idle_ok = bus.Stopstate;
        end
        checks++;
        if (!idle_ok) begin
            failures++;
            $display("FAIL %s idle_wait Stopstate=%b required 1", name, bus.Stopstate);
            return;
        end
        build(n, pl, req_after);
        k = 0;
        drop = -1;
        for (int t = 0; t <= expq.size(); t++) begin
            if (t > 0) begin
                @(negedge clk);
                o = sample();
                checks++;
                if (o !== expq[t-1]) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got lp=%b st=%b ser=%b hs=%b rdy=%b b=%h required lp=%b st=%b ser=%b hs=%b rdy=%b b=%h",
                             name, t-1, o.lp, o.stop, o.ser, o.hs, o.rdy, o.b,
                             expq[t-1].lp, expq[t-1].stop, expq[t-1].ser, expq[t-1].hs,
                             expq[t-1].rdy, expq[t-1].b);
                end
                if (t - 1 == abort_at) begin
                    bus.TxRequestHS = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    o = sample();
                    checks++;
                    if (o !== mk(2'b11, 1, 0, 0, 0, 8'h00)) begin
                        failures++;
                        $display("FAIL %s async_reset got %h required %h", name, o, mk(2'b11, 1, 0, 0, 0, 8'h00));
                    end
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
            end
            if (pulse > 0)
                bus.TxRequestHS = (t < pulse);
            else if (k < n)
                bus.TxRequestHS = 1'b1;
            else begin
                if (drop < 0) drop = t;
                bus.TxRequestHS = (t > drop) ? req_after : 1'b0;
            end
            bus.TxDataHS = (k < n) ? pl[k] : 8'($urandom);
            if (bus.TxReadyHS && bus.TxRequestHS) k++;
        end
        bus.TxRequestHS = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        bus.TxRequestHS = 1'b1;
        bus.TxDataHS = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            o = sample();
            checks++;
            if (o !== mk(2'b11, 1, 0, 0, 0, 8'h00)) begin
                failures++;
                $display("FAIL reset got %h required %h", o, mk(2'b11, 1, 0, 0, 0, 8'h00));
            end
        end
        bus.TxRequestHS = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        logic [7:0] pl[];
        pl = '{8'h11, 8'h22, 8'h83};
        run_burst("nominal", 3, pl, 0, 1'b0, -1);
    endtask

    task automatic test_trail_ff();
        logic [7:0] pl[];
        pl = new[3];
        pl[0] = 8'($urandom);
        pl[1] = 8'($urandom);
        pl[2] = 8'h7F;
        run_burst("trail_ff", 3, pl, 0, 1'b0, -1);
    endtask

    task automatic test_pulse();
        logic [7:0] pl[];
        run_burst("pulse", 0, pl, 2, 1'b0, -1);
    endtask

    task automatic test_hold_exit();
        logic [7:0] pl[];
        pl = '{8'($urandom), 8'($urandom)};
        build(2, pl, 1'b1);
        run_burst("hold_exit", 2, pl, 0, 1'b1, expq.size() - 1);
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] pl[];
        pl = '{8'hC3, 8'h3C, 8'h99, 8'h01};
        run_burst("reset_mid_data", 4, pl, 0, 1'b0, N_LPX + N_PREP + N_ZERO + 2);
        pl = '{8'($urandom), 8'($urandom)};
        run_burst("after_reset", 2, pl, 0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pl[];
        int n;
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 8));
            pl = new[n];
            foreach (pl[i]) pl[i] = 8'($urandom);
            run_burst("back_to_back", n, pl, 0, 1'b0, -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.TxRequestHS = 1'b0;
        bus.TxDataHS = 8'h00;
        test_reset();
        test_nominal();
        test_trail_ff();
        test_pulse();
        test_hold_exit();
        test_reset_mid_data();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
